tl_bus_arb_mux: RTL and testbench
=================================

TL_BUS_ARB_MUX -- requirements
Module: tl_bus_arb_mux

Interface
REQ-001 SHALL have parameter NUM_IN, default 2, number of upstream TileLink-style channels (legal range 1..16).
REQ-002 SHALL have parameter DATA_W, default 32, payload data width.
REQ-003 SHALL have parameter OP_W, default 3, opcode width.
REQ-004 SHALL define local SRC_W = max(1, clog2(NUM_IN)).
REQ-005 SHALL have the following ports:
- clock  in  1  sole clock; all state on rising edge. Reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- io_in_valid  in  NUM_IN  per-channel beat valid.
- io_in_ready  out  NUM_IN  per-channel beat accepted.
- io_in_bits_opcode  in  NUM_IN*OP_W  channel i occupies bits [i*OP_W +: OP_W].
- io_in_bits_data  in  NUM_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- io_in_bits_last  in  NUM_IN  final beat of a burst.
- io_out_ready  in  1  downstream ready.
- io_out_valid  out  1  output register holds a beat.
- io_out_bits_opcode  out  OP_W  registered opcode.
- io_out_bits_data  out  DATA_W  registered data.
- io_out_bits_last  out  1  registered last flag.
- io_out_bits_src  out  SRC_W  index of the channel that supplied the beat.
- io_grantOH  out  NUM_IN  current one-hot grant (combinational); all zero when no channel is valid.

Function
REQ-006 SHALL hold one output register stage (valid, opcode, data, last, src), driving io_out_* directly from that register.
REQ-007 SHALL compute load_en = !io_out_valid | io_out_ready.
REQ-008 SHALL drive io_in_ready[i] = load_en & io_grantOH[i]; a beat transfers on channel i when io_in_valid[i] & io_in_ready[i].
REQ-009 SHALL, when unlocked, grant the first valid channel at or after rr_ptr, searching upward modulo NUM_IN.
REQ-010 SHALL, when locked, grant only lock_idx, and only if io_in_valid[lock_idx] is high; all other channels see ready = 0.
REQ-011 SHALL, on accepting a beat with last = 0, set lock = 1 and lock_idx = the granted index.
REQ-012 SHALL, on accepting a beat with last = 1, clear lock and set rr_ptr = (granted index + 1) mod NUM_IN.
REQ-013 SHALL leave rr_ptr unchanged on every cycle other than a last-beat accept.
REQ-014 SHALL have a latency of exactly one cycle from input accept to io_out_valid = 1.
REQ-015 SHALL sustain one beat per cycle when io_out_ready is held at 1.
REQ-016 SHALL, when an output fire and an input accept happen in the same cycle, reload the register so that io_out_valid stays 1.
REQ-017 SHALL clear io_out_valid on an output fire with no input accept.
REQ-018 SHALL keep all io_out_bits_* stable while io_out_valid & !io_out_ready.
REQ-019 SHALL leave the bits register unchanged whenever no beat is accepted.
REQ-020 SHALL, when NUM_IN = 1, behave as a pipeline register with io_grantOH = io_in_valid and io_out_bits_src = 0.
REQ-021 SHALL keep io_in_ready combinational from io_out_ready and io_in_valid, and SHALL have no combinational path from io_in_bits_* to any output.

Reset
REQ-022 SHALL, while reset = 1 at a clock edge, set io_out_valid = 0, all bits registers = 0, lock = 0, lock_idx = 0 and rr_ptr = 0.
REQ-023 SHALL, if reset is asserted mid-burst, drop lock and the buffered beat; the next grant after reset SHALL start the search from channel 0.
REQ-024 SHALL drive io_in_ready = 0 during a reset cycle.

Structure
REQ-025 SHALL take OP_W default, the TileLink opcode constants and the clog2 helper from the shared package tl_bus_pkg.
REQ-026 SHALL implement the grant logic in one combinational sub-module tl_rr_arbiter (inputs: req vector, rr_ptr, lock, lock_idx; output: one-hot grant).
REQ-027 SHALL hold all sequential state in tl_bus_arb_mux.

Verification
REQ-028 Reset check: NUM_IN=2, assert reset mid-burst -> io_out_valid = 0, lock cleared, next grant goes to channel 0 when both channels are valid.
REQ-029 Round-robin: NUM_IN=4, all valid, all last=1, io_out_ready=1 -> io_out_bits_src sequence 0,1,2,3,0 with one beat per cycle.
REQ-030 Burst lock: ch1 sends a 3-beat burst (last on beat 3) while ch0 is continuously valid -> three consecutive src=1 beats, then src=0.
REQ-031 Backpressure: io_out_ready=0 for 4 cycles with data 32'hDEADBEEF buffered -> io_out_bits constant, all io_in_ready = 0, one fire when ready rises, no lost or duplicated beat.
REQ-032 Sparse request: only ch2 valid with NUM_IN=4 and rr_ptr=3 -> ch2 granted; rr_ptr becomes 3 after its last beat.
REQ-033 Scoreboard: random valid/ready/last traffic over 10k cycles -> output stream equals per-channel input order, and no channel's beats interleave inside a burst.

Source files
------------

// File: rtl/tl_bus_pkg.sv
// Shared TileLink-style bus definitions: default opcode width, A-channel opcodes
// and the sizing helpers used to derive index widths.
package tl_bus_pkg;

   localparam int unsigned TL_OP_W = 3;

   typedef enum logic [TL_OP_W-1:0] {
      TlPutFullData    = 3'd0,
      TlPutPartialData = 3'd1,
      TlArithmeticData = 3'd2,
      TlLogicalData    = 3'd3,
      TlGet            = 3'd4,
      TlIntent         = 3'd5,
      TlAcquireBlock   = 3'd6,
      TlAcquirePerm    = 3'd7
   } tl_a_op_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Index width that stays at least one bit wide for a single channel.
   function automatic int unsigned src_width(input int unsigned n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tl_rr_arbiter.sv
// Combinational round-robin grant with burst lock: locked requests only see
// lock_idx, otherwise the first requester at or above rr_ptr wins, wrapping to 0.
module tl_rr_arbiter
   import tl_bus_pkg::*;
#(
   parameter int unsigned NUM_IN = 2,
   parameter int unsigned SRC_W  = src_width(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SRC_W-1:0]  rr_ptr,
   input  logic              lock,
   input  logic [SRC_W-1:0]  lock_idx,
   output logic [NUM_IN-1:0] grant
);

   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      if (lock) begin
         for (int i = 0; i < NUM_IN; i++) begin
            if (lock_idx == SRC_W'(i)) begin
               grant[i] = req[i];
            end
         end
      end else begin
         // Upper pass covers rr_ptr..NUM_IN-1, lower pass provides the wrap.
         for (int i = 0; i < NUM_IN; i++) begin
            if (!found && req[i] && (SRC_W'(i) >= rr_ptr)) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
         for (int i = 0; i < NUM_IN; i++) begin
            if (!found && req[i]) begin
               grant[i] = 1'b1;
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tl_bus_arb_mux.sv
// N-to-1 TileLink-style channel mux: round-robin arbitration with burst locking
// feeding a single registered output stage.
module tl_bus_arb_mux
   import tl_bus_pkg::*;
#(
   parameter int unsigned NUM_IN = 2,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = TL_OP_W
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_IN-1:0]        io_in_valid,
   output logic [NUM_IN-1:0]        io_in_ready,
   input  logic [NUM_IN*OP_W-1:0]   io_in_bits_opcode,
   input  logic [NUM_IN*DATA_W-1:0] io_in_bits_data,
   input  logic [NUM_IN-1:0]        io_in_bits_last,
   input  logic                     io_out_ready,
   output logic                     io_out_valid,
   output logic [OP_W-1:0]          io_out_bits_opcode,
   output logic [DATA_W-1:0]        io_out_bits_data,
   output logic                     io_out_bits_last,
   output logic [src_width(NUM_IN)-1:0] io_out_bits_src,
   output logic [NUM_IN-1:0]        io_grantOH
);

   localparam int unsigned SRC_W = src_width(NUM_IN);

   logic              out_valid_q, out_valid_d;
   logic [OP_W-1:0]   out_opcode_q, out_opcode_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic [SRC_W-1:0]  out_src_q, out_src_d;
   logic              lock_q, lock_d;
   logic [SRC_W-1:0]  lock_idx_q, lock_idx_d;
   logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [NUM_IN-1:0] grant;
   logic              load_en;
   logic              accept;
   logic [SRC_W-1:0]  sel_idx;
   logic [OP_W-1:0]   sel_opcode;
   logic [DATA_W-1:0] sel_data;
   logic              sel_last;

   tl_rr_arbiter #(
      .NUM_IN (NUM_IN),
      .SRC_W  (SRC_W)
   ) u_arb (
      .req      (io_in_valid),
      .rr_ptr   (rr_ptr_q),
      .lock     (lock_q),
      .lock_idx (lock_idx_q),
      .grant    (grant)
   );

   assign load_en     = !out_valid_q | io_out_ready;
   assign io_in_ready = reset ? '0 : ({NUM_IN{load_en}} & grant);
   assign accept      = |(io_in_valid & io_in_ready);
   assign io_grantOH  = grant;

   // Grant is one-hot, so OR-ing the masked lanes selects the winner.
   always_comb begin
      sel_idx    = '0;
      sel_opcode = '0;
      sel_data   = '0;
      sel_last   = 1'b0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (grant[i]) begin
            sel_idx    = sel_idx | SRC_W'(i);
            sel_opcode = sel_opcode | io_in_bits_opcode[i*OP_W +: OP_W];
            sel_data   = sel_data | io_in_bits_data[i*DATA_W +: DATA_W];
            sel_last   = sel_last | io_in_bits_last[i];
         end
      end
   end

   always_comb begin
      out_valid_d  = out_valid_q;
      out_opcode_d = out_opcode_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      out_src_d    = out_src_q;
      lock_d       = lock_q;
      lock_idx_d   = lock_idx_q;
      rr_ptr_d     = rr_ptr_q;
      if (load_en) begin
         out_valid_d = accept;
      end
      if (accept) begin
         out_opcode_d = sel_opcode;
         out_data_d   = sel_data;
         out_last_d   = sel_last;
         out_src_d    = sel_idx;
         if (sel_last) begin
            lock_d   = 1'b0;
            rr_ptr_d = (sel_idx == SRC_W'(NUM_IN - 1)) ? '0 : sel_idx + SRC_W'(1);
         end else begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_opcode_q <= '0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         out_src_q    <= '0;
         lock_q       <= 1'b0;
         lock_idx_q   <= '0;
         rr_ptr_q     <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_opcode_q <= out_opcode_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         out_src_q    <= out_src_d;
         lock_q       <= lock_d;
         lock_idx_q   <= lock_idx_d;
         rr_ptr_q     <= rr_ptr_d;
      end
   end

   assign io_out_valid       = out_valid_q;
   assign io_out_bits_opcode = out_opcode_q;
   assign io_out_bits_data   = out_data_q;
   assign io_out_bits_last   = out_last_q;
   assign io_out_bits_src    = out_src_q;

endmodule

// File: tb/tb_tl_bus_arb_mux.sv
// Bench for tl_bus_arb_mux: directed scenarios on 4- and 2-channel instances plus
// randomized traffic against a queue-based reference model.
module tb_tl_bus_arb_mux;
   import tl_bus_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int OW = 3;
   localparam int SW = 2;

   typedef struct {
      logic [SW-1:0] src;
      logic [OW-1:0] op;
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic [N-1:0]    in_valid, in_ready, in_last, grant;
   logic [N*OW-1:0] in_op;
   logic [N*DW-1:0] in_data;
   logic            out_ready, out_valid, out_last;
   logic [OW-1:0]   out_op;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_src;

   logic [1:0]  v2, rdy2, l2, g2;
   logic [5:0]  op2;
   logic [63:0] d2;
   logic        or2, ov2, ol2;
   logic [2:0]  oop2;
   logic [31:0] od2;
   logic [0:0]  os2;

   int checks = 0;
   int errors = 0;

   int    m_lock, m_idx, m_ptr;
   beat_t q[$];

   tl_bus_arb_mux #(.NUM_IN(N), .DATA_W(DW), .OP_W(OW)) u_dut (
      .clock              (clock),
      .reset              (reset),
      .io_in_valid        (in_valid),
      .io_in_ready        (in_ready),
      .io_in_bits_opcode  (in_op),
      .io_in_bits_data    (in_data),
      .io_in_bits_last    (in_last),
      .io_out_ready       (out_ready),
      .io_out_valid       (out_valid),
      .io_out_bits_opcode (out_op),
      .io_out_bits_data   (out_data),
      .io_out_bits_last   (out_last),
      .io_out_bits_src    (out_src),
      .io_grantOH         (grant)
   );

   tl_bus_arb_mux #(.NUM_IN(2), .DATA_W(32), .OP_W(3)) u_dut2 (
      .clock              (clock),
      .reset              (reset),
      .io_in_valid        (v2),
      .io_in_ready        (rdy2),
      .io_in_bits_opcode  (op2),
      .io_in_bits_data    (d2),
      .io_in_bits_last    (l2),
      .io_out_ready       (or2),
      .io_out_valid       (ov2),
      .io_out_bits_opcode (oop2),
      .io_out_bits_data   (od2),
      .io_out_bits_last   (ol2),
      .io_out_bits_src    (os2),
      .io_grantOH         (g2)
   );

   task automatic set_ch(input int c, input logic v, input logic l, input logic [DW-1:0] d,
                         input logic [OW-1:0] op);
      in_valid[c]          = v;
      in_last[c]           = l;
      in_data[c*DW +: DW]  = d;
      in_op[c*OW +: OW]    = op;
   endtask

   task automatic clear_inputs();
      in_valid  = '0;
      in_last   = '0;
      in_op     = '0;
      in_data   = '0;
      out_ready = 1'b0;
      v2  = '0;
      l2  = '0;
      op2 = '0;
      d2  = '0;
      or2 = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      clear_inputs();
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Independent view of the arbitration rule: scan upward from the pointer, modulo N.
   function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
      logic [N-1:0] g;
      g = '0;
      if (m_lock != 0) begin
         for (int i = 0; i < N; i++) if (i == m_idx && v[i]) g[i] = 1'b1;
      end else begin
         for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++)
               if (g == '0 && i == (m_ptr + k) % N && v[i]) g[i] = 1'b1;
      end
      return g;
   endfunction

   task automatic test_reset();
      do_reset();
      set_ch(0, 1'b1, 1'b1, 32'h1234_5678, TlGet);
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL reset_preload: out_valid got %b want 1", out_valid);
      end
      out_ready = 1'b1;
      reset     = 1'b1;
      in_valid  = '1;
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
         errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
      end
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if ({out_op, out_data, out_last, out_src} !== '0) begin
         errors++;
         $display("FAIL reset_bits: got op=%h data=%h last=%b src=%0d want all 0",
                  out_op, out_data, out_last, out_src);
      end
      reset = 1'b0;
      clear_inputs();
   endtask

   task automatic test_round_robin();
      int exp_src[5] = '{0, 1, 2, 3, 0};
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b1, 32'hA000_0000 | c, 3'(c));
      for (int j = 0; j < 5; j++) begin
         @(negedge clock);
         checks++;
         if (out_valid !== 1'b1 || out_src !== SW'(exp_src[j])) begin
            errors++;
            $display("FAIL rr_beat%0d: got valid=%b src=%0d want valid=1 src=%0d",
                     j, out_valid, out_src, exp_src[j]);
         end
         checks++;
         if (out_data !== (32'hA000_0000 | exp_src[j])) begin
            errors++;
            $display("FAIL rr_data%0d: got %h want %h", j, out_data, 32'hA000_0000 | exp_src[j]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_burst_lock();
      logic [31:0] exp_d;
      do_reset();
      out_ready = 1'b1;
      set_ch(0, 1'b1, 1'b1, 32'hB000_0000, TlGet);
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd0) begin
         errors++; $display("FAIL burst_pre: got valid=%b src=%0d want 1/0", out_valid, out_src);
      end
      set_ch(1, 1'b1, 1'b0, 32'hB100_0001, TlPutFullData);
      for (int b = 0; b < 4; b++) begin
         @(negedge clock);
         exp_d = (b < 3) ? 32'hB100_0001 + b : 32'hB000_0000;
         checks++;
         if (out_valid !== 1'b1 || out_src !== SW'((b < 3) ? 1 : 0) || out_data !== exp_d
             || out_last !== ((b >= 2) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL burst_beat%0d: got v=%b src=%0d data=%h last=%b want src=%0d data=%h",
                     b, out_valid, out_src, out_data, out_last, (b < 3) ? 1 : 0, exp_d);
         end
         if (b < 2) set_ch(1, 1'b1, (b == 1), 32'hB100_0002 + b, TlPutFullData);
         else set_ch(1, 1'b0, 1'b0, 32'h0, 3'd0);
         if (b == 0) begin
            #1;
            checks++;
            if (in_ready !== 4'b0010) begin
               errors++; $display("FAIL burst_locked_ready: got %b want 0010", in_ready);
            end
         end
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b1;
      set_ch(2, 1'b1, 1'b1, 32'hDEAD_BEEF, TlPutFullData);
      @(negedge clock);
      out_ready = 1'b0;
      set_ch(0, 1'b1, 1'b1, 32'h1111_1111, TlGet);
      set_ch(1, 1'b1, 1'b0, 32'h2222_2222, TlGet);
      set_ch(2, 1'b1, 1'b1, 32'h0BAD_F00D, TlGet);
      set_ch(3, 1'b1, 1'b1, 32'h3333_3333, TlGet);
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_ready%0d: got %b want 0000", k, in_ready);
         end
         @(negedge clock);
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'hDEAD_BEEF || out_src !== 2'd2
             || out_last !== 1'b1 || out_op !== 3'(TlPutFullData)) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b data=%h src=%0d want 1/deadbeef/2",
                     k, out_valid, out_data, out_src);
         end
      end
      out_ready = 1'b1;
      in_valid  = '0;
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_single_fire: got valid=%b want 0", out_valid);
      end
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_no_dup: got valid=%b want 0", out_valid);
      end
      clear_inputs();
   endtask

   task automatic test_sparse();
      do_reset();
      out_ready = 1'b1;
      set_ch(2, 1'b1, 1'b1, 32'hC000_0002, TlGet);
      @(negedge clock);
      set_ch(2, 1'b1, 1'b1, 32'hC000_0012, TlGet);
      #1;
      checks++;
      if (grant !== 4'b0100 || in_ready !== 4'b0100) begin
         errors++; $display("FAIL sparse_grant: got g=%b r=%b want 0100", grant, in_ready);
      end
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== 32'hC000_0012) begin
         errors++;
         $display("FAIL sparse_out: got v=%b src=%0d data=%h want 1/2/c0000012",
                  out_valid, out_src, out_data);
      end
      for (int c = 0; c < N; c++) set_ch(c, 1'b1, 1'b1, 32'hC100_0000 | c, TlGet);
      #1;
      checks++;
      if (grant !== 4'b1000) begin
         errors++; $display("FAIL sparse_ptr3: got grant %b want 1000", grant);
      end
      @(negedge clock);
      checks++;
      if (out_src !== 2'd3) begin
         errors++; $display("FAIL sparse_next: got src %0d want 3", out_src);
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      or2 = 1'b1;
      v2  = 2'b10;
      l2  = 2'b00;
      d2  = {32'h0000_00E1, 32'h0000_00E0};
      @(negedge clock);
      checks++;
      if (ov2 !== 1'b1 || os2 !== 1'b1) begin
         errors++; $display("FAIL mid_pre: got v=%b src=%0d want 1/1", ov2, os2);
      end
      v2 = 2'b11;
      #1;
      checks++;
      if (g2 !== 2'b10) begin
         errors++; $display("FAIL mid_locked: got grant %b want 10", g2);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (rdy2 !== 2'b00) begin
         errors++; $display("FAIL mid_reset_ready: got %b want 00", rdy2);
      end
      @(negedge clock);
      checks++;
      if (ov2 !== 1'b0) begin
         errors++; $display("FAIL mid_reset_valid: got %b want 0", ov2);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (g2 !== 2'b01 || rdy2 !== 2'b01) begin
         errors++; $display("FAIL mid_after_grant: got g=%b r=%b want 01", g2, rdy2);
      end
      @(negedge clock);
      checks++;
      if (ov2 !== 1'b1 || os2 !== 1'b0 || od2 !== 32'h0000_00E0) begin
         errors++;
         $display("FAIL mid_after_out: got v=%b src=%0d data=%h want 1/0/e0", ov2, os2, od2);
      end
      clear_inputs();
   endtask

   task automatic test_random();
      beat_t        b;
      logic [N-1:0] eg, er;
      logic         fire;
      int           ch_seq[N];
      int           ch_left[N];
      logic [2:0]   ch_op[N];
      int           out_seq[N];
      logic         in_burst;
      int           burst_src;
      do_reset();
      m_lock = 0; m_idx = 0; m_ptr = 0;
      q.delete();
      in_burst = 1'b0;
      burst_src = 0;
      for (int c = 0; c < N; c++) begin
         ch_seq[c]  = 0;
         ch_left[c] = $urandom_range(1, 4);
         ch_op[c]   = 3'($urandom_range(0, 7));
         out_seq[c] = 0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         checks++;
         if (out_valid !== (q.size() > 0)) begin
            errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, out_valid, q.size() > 0);
         end
         if (q.size() > 0) begin
            checks++;
            if (out_src !== q[0].src || out_op !== q[0].op || out_last !== q[0].last
                || out_data !== q[0].data) begin
               errors++;
               $display("FAIL rnd_bits@%0d: got src=%0d op=%0d last=%b data=%h want %0d/%0d/%b/%h",
                        cyc, out_src, out_op, out_last, out_data,
                        q[0].src, q[0].op, q[0].last, q[0].data);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         for (int c = 0; c < N; c++)
            set_ch(c, ($urandom_range(0, 9) < 6), (ch_left[c] == 1),
                   {8'(c), 24'(ch_seq[c])}, ch_op[c]);
         #1;
         eg = model_grant(in_valid);
         er = ((q.size() == 0) || out_ready) ? eg : '0;
         checks++;
         if (grant !== eg) begin
            errors++; $display("FAIL rnd_grant@%0d: got %b want %b", cyc, grant, eg);
         end
         checks++;
         if (in_ready !== er) begin
            errors++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready, er);
         end
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (out_data[31:24] !== 8'(out_src) || out_data[23:0] !== 24'(out_seq[out_src])) begin
               errors++;
               $display("FAIL rnd_order@%0d: got src=%0d data=%h want seq %0d", cyc, out_src,
                        out_data, out_seq[out_src]);
            end
            out_seq[out_src]++;
            if (in_burst) begin
               checks++;
               if (int'(out_src) != burst_src) begin
                  errors++;
                  $display("FAIL rnd_interleave@%0d: got src=%0d want %0d", cyc, out_src, burst_src);
               end
            end
            in_burst  = !out_last;
            burst_src = int'(out_src);
         end
         fire = (q.size() > 0) && out_ready;
         if (fire) b = q.pop_front();
         for (int c = 0; c < N; c++) begin
            if (er[c] && in_valid[c]) begin
               b.src  = SW'(c);
               b.op   = ch_op[c];
               b.last = (ch_left[c] == 1);
               b.data = {8'(c), 24'(ch_seq[c])};
               q.push_back(b);
               if (b.last) begin
                  m_lock = 0;
                  m_ptr  = (c + 1) % N;
               end else begin
                  m_lock = 1;
                  m_idx  = c;
               end
               ch_seq[c]++;
               ch_left[c]--;
               if (ch_left[c] == 0) ch_left[c] = $urandom_range(1, 4);
               ch_op[c] = 3'($urandom_range(0, 7));
            end
         end
         @(negedge clock);
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_round_robin();
      test_burst_lock();
      test_backpressure();
      test_sparse();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
